// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_pkg;

  localparam int SPI_BITS = 8;
  localparam logic [SPI_BITS-1:0] IDLE_BYTE_DEF = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_target_if.sv
// SPI pins plus the local byte interface of the SPI target.
interface spi_target_if;
  import spi_pkg::*;

  logic                spi_sck;
  logic                spi_cs;
  logic                spi_mosi;
  logic                spi_miso;
  logic                spi_miso_oe;
  logic [SPI_BITS-1:0] tx_din;
  logic                tx_wr;
  logic                tx_full;
  logic                rx_ren;
  logic [SPI_BITS-1:0] rx_dout;
  logic                rx_data_present;
  logic                rx_overflow;
  logic                tx_underrun;
  logic                clr_flags;
  logic                busy;

  // Target (device) view.
  modport slave (
    input  spi_sck, spi_cs, spi_mosi, tx_din, tx_wr, rx_ren, clr_flags,
    output spi_miso, spi_miso_oe, tx_full, rx_dout, rx_data_present,
           rx_overflow, tx_underrun, busy
  );

  // Initiator / local-host view.
  modport master (
    output spi_sck, spi_cs, spi_mosi, tx_din, tx_wr, rx_ren, clr_flags,
    input  spi_miso, spi_miso_oe, tx_full, rx_dout, rx_data_present,
           rx_overflow, tx_underrun, busy
  );

endinterface

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through FIFO for received bytes. DEPTH must be a power of
// two and at least 2. A push into a full FIFO is accepted only when a pop of
// a non-empty FIFO happens in the same cycle. Head reads as zero when empty.
module spi_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_full;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronises the initiator's pins into clk, shifts bytes
// MSB-first into an RX FIFO and returns bytes from a one-byte TX holding
// register (IDLE_BYTE when nothing is queued).
module spi_target
  import spi_pkg::*;
#(
  parameter int                  RX_DEPTH  = 4,
  parameter logic [SPI_BITS-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input logic         clk,
  input logic         rst,
  spi_target_if.slave bus
);

  localparam int               CNT_W    = $clog2(SPI_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BITS - 1);

  logic r_sck_meta, r_sck_s, r_sck_d;
  logic r_cs_meta, r_cs_s, r_cs_d;
  logic r_mosi_meta, r_mosi_s;
  logic [1:0] r_settle;
  logic r_cs_armed;

  spi_state_e          r_state, w_state_next;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [SPI_BITS-1:0] r_shift_rx, r_shift_tx, r_tx_hold;
  logic                r_tx_full, r_tx_underrun, r_rx_overflow, r_push_pending;

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic w_load, w_shift_tx, w_sample, w_cnt_clr, w_tx_accept, w_overflow;
  logic w_fifo_full, w_fifo_empty;
  logic [SPI_BITS-1:0] w_fifo_dout;

  // Two-flop synchronisers plus a third copy of sck/cs for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_meta  <= 1'b1;  r_sck_s  <= 1'b1;  r_sck_d <= 1'b1;
      r_cs_meta   <= 1'b1;  r_cs_s   <= 1'b1;  r_cs_d  <= 1'b1;
      r_mosi_meta <= 1'b0;  r_mosi_s <= 1'b0;
    end else begin
      r_sck_meta  <= bus.spi_sck;  r_sck_s  <= r_sck_meta;  r_sck_d <= r_sck_s;
      r_cs_meta   <= bus.spi_cs;   r_cs_s   <= r_cs_meta;   r_cs_d  <= r_cs_s;
      r_mosi_meta <= bus.spi_mosi; r_mosi_s <= r_mosi_meta;
    end
  end

  // Arm cs only after the synchronised cs is seen high once the chain has
  // flushed its reset value, so a cs already low out of reset is not a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle   <= 2'd0;
      r_cs_armed <= 1'b0;
    end else begin
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if (r_settle == 2'd3 && r_cs_s) r_cs_armed <= 1'b1;
    end
  end

  assign w_sck_rise = r_sck_s & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s & r_sck_d;
  assign w_cs_fall  = r_cs_armed & r_cs_d & ~r_cs_s;
  assign w_cs_rise  = r_cs_s & ~r_cs_d;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift_tx   = 1'b0;
    w_sample     = 1'b0;
    w_cnt_clr    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_next = ACTIVE;
          w_load       = 1'b1;
          w_cnt_clr    = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_next = IDLE;
          w_cnt_clr    = 1'b1;
        end else begin
          w_sample = w_sck_rise;
          if (w_sck_fall) begin
            if (r_bit_cnt == '0) w_load     = 1'b1;
            else                 w_shift_tx = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Receive shifter and bit counter; a completed byte is pushed next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt      <= '0;
      r_shift_rx     <= '0;
      r_push_pending <= 1'b0;
    end else begin
      if (w_cnt_clr)     r_bit_cnt <= '0;
      else if (w_sample) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_sample) r_shift_rx <= {r_shift_rx[SPI_BITS-2:0], r_mosi_s};
      r_push_pending <= w_sample && (r_bit_cnt == LAST_BIT);
    end
  end

  // A write is taken only into an empty holding register; a load in the same
  // cycle sees the pre-write occupancy.
  assign w_tx_accept = bus.tx_wr & ~r_tx_full;

  // Transmit shifter and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_tx <= '0;
      r_tx_hold  <= '0;
      r_tx_full  <= 1'b0;
    end else begin
      if (w_load)          r_shift_tx <= r_tx_full ? r_tx_hold : IDLE_BYTE;
      else if (w_shift_tx) r_shift_tx <= {r_shift_tx[SPI_BITS-2:0], 1'b0};
      if (w_tx_accept) r_tx_hold <= bus.tx_din;
      if (w_load && r_tx_full) r_tx_full <= 1'b0;
      else if (w_tx_accept)    r_tx_full <= 1'b1;
    end
  end

  assign w_overflow = r_push_pending & w_fifo_full & ~bus.rx_ren;

  // Sticky status flags; setting wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_underrun <= 1'b0;
      r_rx_overflow <= 1'b0;
    end else begin
      if (w_load && !r_tx_full) r_tx_underrun <= 1'b1;
      else if (bus.clr_flags)   r_tx_underrun <= 1'b0;
      if (w_overflow)           r_rx_overflow <= 1'b1;
      else if (bus.clr_flags)   r_rx_overflow <= 1'b0;
    end
  end

  spi_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (SPI_BITS)
  ) u_rx_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_push_pending),
    .i_pop   (bus.rx_ren),
    .i_din   (r_shift_rx),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_dout  (w_fifo_dout)
  );

  assign bus.spi_miso        = (r_state == ACTIVE) ? r_shift_tx[SPI_BITS-1] : 1'b1;
  assign bus.spi_miso_oe     = (r_state == ACTIVE) & ~r_cs_s;
  assign bus.busy            = (r_state == ACTIVE) & ~r_cs_s;
  assign bus.tx_full         = r_tx_full;
  assign bus.rx_dout         = w_fifo_dout;
  assign bus.rx_data_present = ~w_fifo_empty;
  assign bus.rx_overflow     = r_rx_overflow;
  assign bus.tx_underrun     = r_tx_underrun;

endmodule

// File: tb/tb_spi_target.sv
// Randomised scoreboard bench for spi_target: an SPI initiator drives the pins
// at clk/12, a byte-level model predicts RX FIFO contents, miso bytes and flags.
module tb_spi_target;
  import spi_pkg::*;

  localparam int          RX_DEPTH = 4;
  localparam logic [7:0]  IDLE_B   = 8'hFF;
  localparam int          HALF     = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_target_if bus ();

  spi_target #(
    .RX_DEPTH  (RX_DEPTH),
    .IDLE_BYTE (IDLE_B)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];
  logic [7:0] miso_obs[$];
  logic [7:0] q_bytes[$];
  bit         m_full, m_unr, m_ovf;
  logic [7:0] m_hold;
  bit         drain_en = 1'b0;
  bit         pop_now  = 1'b0;
  logic [7:0] mon_e, mon_o, mon_x;

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: what a load point shifts out, and its effect on the holding model.
  function automatic logic [7:0] model_load();
    if (m_full) begin
      m_full = 1'b0;
      return m_hold;
    end
    m_unr = 1'b1;
    return IDLE_B;
  endfunction

  // RX monitor: pops the FIFO head when draining (or on request) and scores it.
  initial begin
    bus.rx_ren = 1'b0;
    forever begin
      @(negedge clk);
      bus.rx_ren = 1'b0;
      if ((drain_en || pop_now) && bus.rx_data_present === 1'b1) begin
        if (rx_exp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got %02h required none", bus.rx_dout);
        end else begin
          mon_e = rx_exp.pop_front();
          check8("rx_dout", bus.rx_dout, mon_e);
          $display("[TB] rx pop %02h (exp %02h)", bus.rx_dout, mon_e);
        end
        bus.rx_ren = 1'b1;
      end
    end
  end

  // MISO monitor: scores every byte the initiator clocked in.
  initial begin
    forever begin
      @(negedge clk);
      if (miso_obs.size() > 0) begin
        mon_o = miso_obs.pop_front();
        mon_x = miso_exp.pop_front();
        check8("miso_byte", mon_o, mon_x);
        $display("[TB] miso byte %02h (exp %02h)", mon_o, mon_x);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    bus.tx_din = b;
    bus.tx_wr  = 1'b1;
    if (!m_full) begin
      m_hold = b;
      m_full = 1'b1;
    end
    @(negedge clk);
    bus.tx_wr = 1'b0;
  endtask

  task automatic clr_flags_pulse();
    @(negedge clk);
    bus.clr_flags = 1'b1;
    m_unr = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    bus.clr_flags = 1'b0;
  endtask

  task automatic check_flags();
    repeat (2) @(negedge clk);
    check1("tx_underrun", bus.tx_underrun, m_unr);
    check1("rx_overflow", bus.rx_overflow, m_ovf);
    check1("tx_full", bus.tx_full, m_full);
  endtask

  // One MSB-first byte; optionally pops the FIFO in the cycle the byte is pushed
  // (8th pin rise + 2 sync flops + 1 detect register).
  task automatic spi_byte(input logic [7:0] b, input bit pop_last, output logic [7:0] rcv);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = b[i];
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b1;
      rcv[i] = bus.spi_miso;
      if (i == 0) begin
        if (rx_exp.size() < RX_DEPTH || pop_last) rx_exp.push_back(b);
        else m_ovf = 1'b1;
      end
      if (i == 0 && pop_last) begin
        repeat (3) @(posedge clk);
        #2 pop_now = 1'b1;
        @(posedge clk);
        #2 pop_now = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.spi_sck = 1'b0;
    end
  endtask

  // Full transaction over q_bytes; pop_idx selects a byte whose push gets a pop.
  task automatic spi_xfer(input int pop_idx);
    logic [7:0] cur, rcv;
    @(negedge clk);
    bus.spi_cs = 1'b0;
    cur = model_load();
    repeat (8) @(negedge clk);
    check1("busy_active", bus.busy, 1'b1);
    for (int k = 0; k < q_bytes.size(); k++) begin
      spi_byte(q_bytes[k], (k == pop_idx), rcv);
      miso_exp.push_back(cur);
      miso_obs.push_back(rcv);
      $display("[TB] spi byte mosi=%02h miso=%02h", q_bytes[k], rcv);
      cur = model_load();
    end
    repeat (HALF) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    drain_en = 1'b1;
    while ((rx_exp.size() != 0 || bus.rx_data_present === 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    drain_en = 1'b0;
    checkn("drain_left", rx_exp.size(), 0);
    check1("drain_present", bus.rx_data_present, 1'b0);
  endtask

  initial begin
    int nb;
    bus.spi_sck = 1'b0; bus.spi_cs = 1'b1; bus.spi_mosi = 1'b0;
    bus.tx_din = '0; bus.tx_wr = 1'b0; bus.clr_flags = 1'b0;
    m_full = 1'b0; m_unr = 1'b0; m_ovf = 1'b0; m_hold = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check1("rst_miso", bus.spi_miso, 1'b1);
    check1("rst_oe", bus.spi_miso_oe, 1'b0);
    check1("rst_tx_full", bus.tx_full, 1'b0);
    check1("rst_present", bus.rx_data_present, 1'b0);
    check1("rst_ovf", bus.rx_overflow, 1'b0);
    check1("rst_unr", bus.tx_underrun, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check8("rst_dout", bus.rx_dout, 8'h00);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // 1: queued A5 returned while 3C is received
    tx_write(8'hA5);
    check1("t1_tx_full", bus.tx_full, 1'b1);
    q_bytes = {8'h3C};
    spi_xfer(-1);
    check1("t1_present", bus.rx_data_present, 1'b1);
    check8("t1_head", bus.rx_dout, 8'h3C);
    check_flags();
    drain();
    clr_flags_pulse();

    // 2: burst with no queued data returns idle bytes
    q_bytes = {8'h01, 8'h02, 8'h03};
    spi_xfer(-1);
    check_flags();
    drain();
    clr_flags_pulse();
    check1("t2_unr_cleared", bus.tx_underrun, 1'b0);

    // 3: five bytes into a four-deep FIFO
    q_bytes.delete();
    for (int k = 0; k < 5; k++) q_bytes.push_back(8'($urandom));
    spi_xfer(-1);
    check_flags();
    drain();
    clr_flags_pulse();
    check1("t3_ovf_cleared", bus.rx_overflow, 1'b0);

    // 4: full FIFO with a pop on the push cycle of 55
    q_bytes.delete();
    for (int k = 0; k < 4; k++) q_bytes.push_back(8'($urandom));
    spi_xfer(-1);
    q_bytes = {8'h55};
    spi_xfer(0);
    check_flags();
    drain();
    clr_flags_pulse();

    // 5: partial byte aborted by cs rise, then a clean byte
    @(negedge clk);
    bus.spi_cs = 1'b0;
    void'(model_load());
    repeat (8) @(negedge clk);
    for (int i = 7; i >= 3; i--) begin
      bus.spi_mosi = (i >= 4);
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    check1("t5_busy", bus.busy, 1'b0);
    check1("t5_present", bus.rx_data_present, 1'b0);
    q_bytes = {8'h81};
    spi_xfer(-1);
    check8("t5_head", bus.rx_dout, 8'h81);
    check_flags();
    drain();
    clr_flags_pulse();

    // 6: reset mid-byte with cs held low
    tx_write(8'h77);
    @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.spi_mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    rst = 1'b1;
    #1;
    check1("t6_miso", bus.spi_miso, 1'b1);
    check1("t6_oe", bus.spi_miso_oe, 1'b0);
    check1("t6_tx_full", bus.tx_full, 1'b0);
    check1("t6_present", bus.rx_data_present, 1'b0);
    check1("t6_ovf", bus.rx_overflow, 1'b0);
    check1("t6_unr", bus.tx_underrun, 1'b0);
    check1("t6_busy", bus.busy, 1'b0);
    check8("t6_dout", bus.rx_dout, 8'h00);
    m_full = 1'b0; m_unr = 1'b0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.spi_mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    repeat (8) @(negedge clk);
    check1("t6_no_busy", bus.busy, 1'b0);
    check1("t6_no_oe", bus.spi_miso_oe, 1'b0);
    check1("t6_no_rx", bus.rx_data_present, 1'b0);
    check1("t6_no_unr", bus.tx_underrun, 1'b0);
    bus.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    tx_write(8'h5A);
    q_bytes = {8'hC3};
    spi_xfer(-1);
    check_flags();
    drain();
    clr_flags_pulse();

    // Randomised transactions with the FIFO drained as bytes arrive
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      if ($urandom_range(0, 3) == 0) tx_write(8'($urandom));
      q_bytes.delete();
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) q_bytes.push_back(8'($urandom));
      drain_en = 1'b1;
      spi_xfer(-1);
      drain();
      check_flags();
      clr_flags_pulse();
    end

    repeat (4) @(negedge clk);
    checkn("miso_pending", miso_obs.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
